uart_port: RTL and testbench
============================

Name: uart_port

Overview:
Memory-mapped UART peripheral that sits on the SoC data bus beside the digital ports and timer, decoded at 0xF2000000 (8 bytes). It provides:
- a TX FIFO feeding an 8N1 serialiser;
- an RX deserialiser feeding an RX FIFO;
- a status/divisor register.

The CPU pushes bytes by bus writes and pops received bytes by bus reads.

Parameters:
FIFO_DEPTH, 8, entries per FIFO (power of two, 2..64).
DEFAULT_DIV, 434, clocks per bit after reset (115200 baud at 50 MHz).

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
chipSelect  in  1  bus address decodes to this block.
write  in  1  write strobe to offset 0 (DATA).
writeCommand  in  1  write strobe to offset 4 (CTRL).
readData  in  1  single-cycle pop strobe: bus read of offset 0 completed.
dataIn  in  32  bus write data.
addrSel  in  1  0 = DATA, 1 = STATUS for dataOut.
dataOut  out  32  combinational read data.
txd  out  1  serial out, idle high.
rxd  in  1  serial in, asynchronous to clk.
irq  out  1  level: RX FIFO non-empty.

Behaviour:
Register map
- DATA write (chipSelect && write): push dataIn[7:0] to TX FIFO. If TX FIFO is full, drop the byte and set txOverflow.
- DATA read: dataOut = {24'b0, RX head}. dataOut = 0 when RX FIFO is empty. A readData pulse pops one entry; a pop on empty is ignored.
- STATUS read: dataOut = {divisor[15:0], 8'b0, rxOverflow, txOverflow, framingErr, txBusy, rxFull, rxEmpty, txFull, txEmpty} (bits 7..0).
- CTRL write (chipSelect && writeCommand):
  - dataIn[31:16] loads divisor if nonzero; divisor values below 4 are clamped to 4.
  - dataIn[0] = 1 clears all three sticky error flags.
  - A CTRL write during an active frame takes effect at the next bit boundary.
- Strobes without chipSelect are ignored.

Reset values (asynchronous)
- Both FIFOs empty; all pointers 0.
- txd = 1, irq = 0, error flags 0, divisor = DEFAULT_DIV.
- Both FSMs in IDLE; dataOut reflects the empty/reset state.
- A reset mid-frame aborts the frame immediately; txd goes high the same cycle.

FIFOs
- Circular buffers with log2(FIFO_DEPTH)+1-bit read/write pointers.
- full when pointer MSBs differ and lower bits are equal.
- Simultaneous push and pop on a full FIFO: both succeed, and the FIFO stays full.
- Simultaneous push and pop on an empty FIFO: the push succeeds and the pop is ignored.
- Pointers wrap modulo 2*FIFO_DEPTH.

TX FSM (IDLE, START, DATA, STOP)
- IDLE: when TX FIFO is non-empty, pop the head into the shift register, then go to START.
- START: txd = 0 for divisor clocks.
- DATA: 8 bits LSB-first, each held for divisor clocks.
- STOP: txd = 1 for divisor clocks, then IDLE.
- Latency from push into an empty idle TX to the txd falling edge: 2 clocks.
- Back-to-back bytes have no idle gap; each frame is exactly 10*divisor clocks.
- txBusy = (state != IDLE) || !txEmpty.

RX path (IDLE, START, DATA, STOP)
- rxd passes through a 2-FF synchroniser, reset to 1.
- IDLE: a falling edge on the synchronised rxd starts a counter.
- START: at divisor/2 clocks, recheck rxd. If high, treat it as a glitch and return to IDLE. If low, go to DATA.
- DATA: sample 8 bits at full-divisor intervals (mid-bit), LSB-first.
- STOP: sample at mid-bit.
  - Stop = 1: push the byte to the RX FIFO.
  - Stop = 0: set framingErr and discard the byte.
  - Then return to IDLE.
- STOP waits for rxd high before re-arming, so a break condition does not retrigger.
- Push when RX FIFO is full: drop the byte and set rxOverflow; the FIFO contents are unchanged.
- The RX FIFO push and a CPU pop in the same cycle follow the FIFO rules above.

Timing and interrupt
- The bit counter is 16 bits; it counts divisor-1 down to 0 per bit.
- irq = !rxEmpty, registered (1 clock after the push).

Test Plan:
- Reset, then STATUS read -> 0x01B20005 (divisor 434, txEmpty = 1, rxEmpty = 1); txd = 1; irq = 0.
- CTRL write 0x00100000 (divisor 16), then DATA write 0x55 -> txd falls 2 clocks later. The 160-clock frame reads 0,1,0,1,0,1,0,1,0,1 per 16-clock bit (start bit, LSB first, stop bit). txEmpty returns at frame end.
- Divisor 16; write 9 bytes 0x00..0x08 back-to-back with FIFO_DEPTH = 8. The first byte is popped to the shifter after 1 clock, so all 9 are accepted with no txOverflow. A 10th write while full sets txOverflow. 9 contiguous frames follow with no idle cycles.
- Drive rxd with 8N1 frame 0xA3 at divisor 16 -> irq rises after the stop-bit sample. DATA read = 0x000000A3; a readData pulse sets rxEmpty = 1 and irq drops next clock.
- Drive a 4-clock low glitch on rxd -> no push, no framingErr. Drive a frame with stop bit 0 -> framingErr = 1, FIFO empty. CTRL write 0x1 -> framingErr = 0 and divisor unchanged.
- Assert reset mid-TX frame (bit 3) and mid-RX frame -> txd = 1 immediately. After release, STATUS equals the reset value and no partial byte appears in the RX FIFO.

Source files
------------

// File: rtl/uart_port.sv
// Memory-mapped 8N1 UART: TX FIFO + serialiser, RX deserialiser + FIFO,
// status/divisor register. Asynchronous active-high reset.
module uart_port #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipSelect,
  input  logic        write,
  input  logic        writeCommand,
  input  logic        readData,
  input  logic [31:0] dataIn,
  input  logic        addrSel,
  output logic [31:0] dataOut,
  output logic        txd,
  input  logic        rxd,
  output logic        irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [15:0] divisor;
  logic        txOverflow, rxOverflow, framingErr;
  logic        ctrlWr;
  logic        unusedDataBits;

  assign ctrlWr         = chipSelect && writeCommand;
  assign unusedDataBits = ^dataIn[15:8];

  // ---------------- TX FIFO ----------------
  logic [7:0]  txMem [FIFO_DEPTH];
  logic [AW:0] txWr, txRd;
  logic        txEmpty, txFull, txPush, txPop, txBusy;
  state_t      txState;
  logic [15:0] txCnt;
  logic [7:0]  txShift;
  logic [2:0]  txBit;

  assign txEmpty = (txWr == txRd);
  assign txFull  = (txWr[AW] != txRd[AW]) && (txWr[AW-1:0] == txRd[AW-1:0]);
  // The serialiser pops in IDLE or on the last STOP clock, which lets a push
  // into a full FIFO succeed in that cycle and keeps frames contiguous.
  assign txPop   = !txEmpty && ((txState == IDLE) || (txState == STOP && txCnt == '0));
  assign txPush  = chipSelect && write && (!txFull || txPop);
  assign txBusy  = (txState != IDLE) || !txEmpty;

  always_ff @(posedge clk) begin
    if (txPush) txMem[txWr[AW-1:0]] <= dataIn[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txWr <= '0;
      txRd <= '0;
    end else begin
      if (txPush) txWr <= txWr + 1'b1;
      if (txPop)  txRd <= txRd + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txState <= IDLE;
      txd     <= 1'b1;
      txCnt   <= '0;
      txShift <= '0;
      txBit   <= '0;
    end else begin
      case (txState)
        IDLE: begin
          if (txPop) begin
            txShift <= txMem[txRd[AW-1:0]];
            txCnt   <= divisor - 16'd1;
            txd     <= 1'b0;
            txState <= START;
          end
        end
        START: begin
          if (txCnt != '0) txCnt <= txCnt - 16'd1;
          else begin
            txd     <= txShift[0];
            txShift <= {1'b0, txShift[7:1]};
            txBit   <= '0;
            txCnt   <= divisor - 16'd1;
            txState <= DATA;
          end
        end
        DATA: begin
          if (txCnt != '0) txCnt <= txCnt - 16'd1;
          else begin
            txCnt <= divisor - 16'd1;
            if (txBit == 3'd7) begin
              txd     <= 1'b1;
              txState <= STOP;
            end else begin
              txd     <= txShift[0];
              txShift <= {1'b0, txShift[7:1]};
              txBit   <= txBit + 3'd1;
            end
          end
        end
        STOP: begin
          if (txCnt != '0) txCnt <= txCnt - 16'd1;
          else if (txPop) begin
            txShift <= txMem[txRd[AW-1:0]];
            txCnt   <= divisor - 16'd1;
            txd     <= 1'b0;
            txState <= START;
          end else begin
            txState <= IDLE;
          end
        end
        default: txState <= IDLE;
      endcase
    end
  end

  // ---------------- RX path ----------------
  logic        rs1, rs2, rsPrev;
  state_t      rxState;
  logic [15:0] rxCnt;
  logic [7:0]  rxShift;
  logic [2:0]  rxBit;
  logic        rxStopDone, rxPushReq, rxFrameErr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs1        <= 1'b1;
      rs2        <= 1'b1;
      rsPrev     <= 1'b1;
      rxState    <= IDLE;
      rxCnt      <= '0;
      rxShift    <= '0;
      rxBit      <= '0;
      rxStopDone <= 1'b0;
      rxPushReq  <= 1'b0;
      rxFrameErr <= 1'b0;
    end else begin
      rs1        <= rxd;
      rs2        <= rs1;
      rsPrev     <= rs2;
      rxPushReq  <= 1'b0;
      rxFrameErr <= 1'b0;
      case (rxState)
        IDLE: begin
          if (rsPrev && !rs2) begin
            rxCnt   <= {1'b0, divisor[15:1]} - 16'd1;
            rxState <= START;
          end
        end
        START: begin
          if (rxCnt != '0) rxCnt <= rxCnt - 16'd1;
          else if (rs2) rxState <= IDLE;
          else begin
            rxCnt   <= divisor - 16'd1;
            rxBit   <= '0;
            rxState <= DATA;
          end
        end
        DATA: begin
          if (rxCnt != '0) rxCnt <= rxCnt - 16'd1;
          else begin
            rxShift <= {rs2, rxShift[7:1]};
            rxCnt   <= divisor - 16'd1;
            if (rxBit == 3'd7) begin
              rxStopDone <= 1'b0;
              rxState    <= STOP;
            end else begin
              rxBit <= rxBit + 3'd1;
            end
          end
        end
        STOP: begin
          // After the stop sample, hold here until the line is high so a
          // break does not immediately look like a new start bit.
          if (!rxStopDone) begin
            if (rxCnt != '0) rxCnt <= rxCnt - 16'd1;
            else begin
              rxStopDone <= 1'b1;
              if (rs2) rxPushReq  <= 1'b1;
              else     rxFrameErr <= 1'b1;
            end
          end else if (rs2) begin
            rxState <= IDLE;
          end
        end
        default: rxState <= IDLE;
      endcase
    end
  end

  logic [7:0]  rxMem [FIFO_DEPTH];
  logic [AW:0] rxWr, rxRd;
  logic        rxEmpty, rxFull, rxPush, rxPop;

  assign rxEmpty = (rxWr == rxRd);
  assign rxFull  = (rxWr[AW] != rxRd[AW]) && (rxWr[AW-1:0] == rxRd[AW-1:0]);
  assign rxPop   = chipSelect && readData && !rxEmpty;
  assign rxPush  = rxPushReq && (!rxFull || rxPop);

  always_ff @(posedge clk) begin
    if (rxPush) rxMem[rxWr[AW-1:0]] <= rxShift;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxWr <= '0;
      rxRd <= '0;
      irq  <= 1'b0;
    end else begin
      if (rxPush) rxWr <= rxWr + 1'b1;
      if (rxPop)  rxRd <= rxRd + 1'b1;
      irq <= !rxEmpty;
    end
  end

  // ---------------- Control / status ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divisor    <= DEFAULT_DIV;
      txOverflow <= 1'b0;
      rxOverflow <= 1'b0;
      framingErr <= 1'b0;
    end else begin
      if (ctrlWr && dataIn[31:16] != '0)
        divisor <= (dataIn[31:16] < 16'd4) ? 16'd4 : dataIn[31:16];
      if (ctrlWr && dataIn[0]) begin
        txOverflow <= 1'b0;
        rxOverflow <= 1'b0;
        framingErr <= 1'b0;
      end
      if (chipSelect && write && !txPush) txOverflow <= 1'b1;
      if (rxPushReq && !rxPush)           rxOverflow <= 1'b1;
      if (rxFrameErr)                     framingErr <= 1'b1;
    end
  end

  always_comb begin
    dataOut = '0;
    if (addrSel)
      dataOut = {divisor, 8'h00, rxOverflow, txOverflow, framingErr, txBusy,
                 rxFull, rxEmpty, txFull, txEmpty};
    else if (!rxEmpty)
      dataOut[7:0] = rxMem[rxRd[AW-1:0]];
  end

endmodule

// File: tb/tb_uart_port.sv
// Scoreboarded bench for uart_port: serial TX decoder and bus-pop monitor
// compare against queues filled by the stimulus thread.
module tb_uart_port;

  logic        clk = 1'b0;
  logic        reset, chipSelect, write, writeCommand, readData, addrSel, rxd;
  logic [31:0] dataIn, dataOut;
  logic        txd, irq;

  always #5 clk = ~clk;

  uart_port #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd434)) dut (
    .clk(clk), .reset(reset), .chipSelect(chipSelect), .write(write),
    .writeCommand(writeCommand), .readData(readData), .dataIn(dataIn),
    .addrSel(addrSel), .dataOut(dataOut), .txd(txd), .rxd(rxd), .irq(irq)
  );

  int          nCmp = 0;
  int          nErr = 0;
  int unsigned tbDiv = 434;
  bit          txMonEn = 1'b0;
  int          cyc = 0;
  logic [7:0]  txExp[$];
  logic [7:0]  rxExp[$];
  int          fallQ[$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // TX monitor: decode 8N1 frames from txd at mid-bit
  logic [7:0] monByte;
  logic       monStart, monStop;
  initial begin
    forever begin
      @(negedge clk);
      if (txMonEn && txd === 1'b0) begin
        fallQ.push_back(cyc);
        repeat (tbDiv / 2) @(negedge clk);
        monStart = txd;
        for (int i = 0; i < 8; i++) begin
          repeat (tbDiv) @(negedge clk);
          monByte[i] = txd;
        end
        repeat (tbDiv) @(negedge clk);
        monStop = txd;
        check("tx_start_bit", {31'b0, monStart}, 32'h0);
        if (txExp.size() == 0) begin
          nCmp++;
          nErr++;
          $display("FAIL tx_unexpected: got frame 0x%02h expected no frame", monByte);
        end else begin
          check("tx_byte", {24'b0, monByte}, {24'b0, txExp.pop_front()});
        end
        check("tx_stop_bit", {31'b0, monStop}, 32'h1);
      end
    end
  end

  // RX monitor: every bus pop must return the next expected received byte
  initial begin
    forever begin
      @(negedge clk);
      if (chipSelect && readData && !addrSel) begin
        if (rxExp.size() == 0) begin
          nCmp++;
          nErr++;
          $display("FAIL rx_unexpected_pop: got 0x%08h expected nothing", dataOut);
        end else begin
          check("rx_data", dataOut, {24'b0, rxExp.pop_front()});
        end
      end
    end
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [31:0] d);
    chipSelect = 1'b1; write = 1'b1; dataIn = d;
    tick(1);
    chipSelect = 1'b0; write = 1'b0;
  endtask

  task automatic ctrl(input logic [31:0] d);
    chipSelect = 1'b1; writeCommand = 1'b1; dataIn = d;
    tick(1);
    chipSelect = 1'b0; writeCommand = 1'b0;
    if (d[31:16] != 16'd0) tbDiv = (d[31:16] < 16'd4) ? 4 : int'(d[31:16]);
  endtask

  task automatic busPop();
    chipSelect = 1'b1; readData = 1'b1; addrSel = 1'b0;
    tick(1);
    chipSelect = 1'b0; readData = 1'b0;
  endtask

  task automatic readReg(input logic a, output logic [31:0] v);
    addrSel = a;
    #1;
    v = dataOut;
  endtask

  task automatic sendRx(input logic [7:0] b, input logic stopBit);
    rxd = 1'b0;
    tick(tbDiv);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(tbDiv);
    end
    rxd = stopBit;
    tick(tbDiv);
    rxd = 1'b1;
  endtask

  task automatic waitTxIdle();
    logic [31:0] s;
    int n;
    n = 0;
    readReg(1'b1, s);
    while (s[4] && n < 6000) begin
      tick(1);
      readReg(1'b1, s);
      n++;
    end
    check("tx_idle_wait", {31'b0, s[4]}, 32'h0);
    tick(2);
    check("tx_queue_drained", txExp.size(), 32'h0);
  endtask

  task automatic waitIrq();
    int n;
    n = 0;
    while (!irq && n < 1000) begin
      tick(1);
      n++;
    end
    check("irq_wait", {31'b0, irq}, 32'h1);
  endtask

  logic [31:0] s;
  logic [7:0]  b;
  int          n;

  initial begin
    reset = 1'b1; chipSelect = 1'b0; write = 1'b0; writeCommand = 1'b0;
    readData = 1'b0; addrSel = 1'b0; dataIn = '0; rxd = 1'b1;
    tick(3);
    check("txd_in_reset", {31'b0, txd}, 32'h1);
    reset = 1'b0;
    tick(1);
    readReg(1'b1, s);
    check("status_reset", s, 32'h01B2_0005);
    check("irq_reset", {31'b0, irq}, 32'h0);
    readReg(1'b0, s);
    check("data_empty", s, 32'h0);

    // Single frame at divisor 16 with exact start latency and frame length
    ctrl(32'h0010_0000);
    readReg(1'b1, s);
    check("status_div16", s, 32'h0010_0005);
    txMonEn = 1'b1;
    txExp.push_back(8'h55);
    busWrite(32'h55);
    check("tx_latency_e0", {31'b0, txd}, 32'h1);
    tick(1);
    check("tx_latency_e1", {31'b0, txd}, 32'h0);
    tick(159);
    readReg(1'b1, s);
    check("tx_busy_last_clk", {31'b0, s[4]}, 32'h1);
    tick(1);
    readReg(1'b1, s);
    check("tx_idle_after_frame", s[7:0], 32'h05);
    tick(2);

    // Nine back-to-back writes fit (one is in the shifter); the tenth overflows
    fallQ.delete();
    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin
        readReg(1'b1, s);
        check("tx_full_no_overflow", {30'b0, s[6], s[1]}, 32'h1);
      end
      if (i < 9) txExp.push_back(8'(i));
      busWrite(32'(i));
    end
    readReg(1'b1, s);
    check("tx_overflow_set", {31'b0, s[6]}, 32'h1);
    waitTxIdle();
    check("tx_frame_count", fallQ.size(), 32'd9);
    for (int i = 1; i < fallQ.size(); i++)
      check("tx_frame_spacing", fallQ[i] - fallQ[i-1], 32'd160);
    ctrl(32'h1);
    readReg(1'b1, s);
    check("tx_overflow_cleared", s, 32'h0010_0005);

    // Single RX frame, irq timing around the pop
    rxExp.push_back(8'hA3);
    sendRx(8'hA3, 1'b1);
    waitIrq();
    readReg(1'b0, s);
    check("rx_peek", s, 32'h0000_00A3);
    busPop();
    readReg(1'b1, s);
    check("rx_empty_after_pop", {31'b0, s[2]}, 32'h1);
    check("irq_lags_pop", {31'b0, irq}, 32'h1);
    tick(1);
    check("irq_drops", {31'b0, irq}, 32'h0);

    // Glitch, framing error, break, clear
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(40);
    readReg(1'b1, s);
    check("glitch_ignored", s[7:0], 32'h05);
    sendRx(8'h5A, 1'b0);
    tick(20);
    readReg(1'b1, s);
    check("framing_err", s[7:0], 32'h25);
    rxd = 1'b0;
    tick(tbDiv * 20);
    rxd = 1'b1;
    tick(40);
    readReg(1'b1, s);
    check("break_no_push", s[7:0], 32'h25);
    check("break_no_irq", {31'b0, irq}, 32'h0);
    ctrl(32'h1);
    readReg(1'b1, s);
    check("framing_cleared", s, 32'h0010_0005);

    // Randomised bursts at random divisors
    for (int r = 0; r < 2; r++) begin
      ctrl({16'($urandom_range(8, 40)), 16'h0});
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        txExp.push_back(b);
        busWrite({24'b0, b});
      end
      waitTxIdle();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        rxExp.push_back(b);
        sendRx(b, 1'b1);
      end
      waitIrq();
      tick(2 * tbDiv);
      for (int i = 0; i < n; i++) busPop();
      tick(2);
      check("rx_random_drained", rxExp.size(), 32'h0);
      check("rx_random_irq_low", {31'b0, irq}, 32'h0);
    end

    // RX overflow: ninth frame is dropped, contents preserved
    ctrl(32'h0010_0000);
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      if (i < 8) rxExp.push_back(b);
      sendRx(b, 1'b1);
    end
    tick(40);
    readReg(1'b1, s);
    check("rx_overflow_status", s[7:0], 32'h89);
    for (int i = 0; i < 8; i++) busPop();
    tick(1);
    readReg(1'b1, s);
    check("rx_after_drain", s[7:0], 32'h85);
    ctrl(32'h1);

    // Reset during TX bit 3 and mid RX frame
    txMonEn = 1'b0;
    tick(2);
    fork
      sendRx(8'hF8, 1'b1);
      begin
        busWrite(32'h00);
        tick(70);
        check("tx_low_before_reset", {31'b0, txd}, 32'h0);
        reset = 1'b1;
        #1;
        check("txd_async_reset", {31'b0, txd}, 32'h1);
        tick(3);
        reset = 1'b0;
      end
    join
    tbDiv = 434;
    tick(300);
    readReg(1'b1, s);
    check("status_after_reset", s, 32'h01B2_0005);
    check("irq_after_reset", {31'b0, irq}, 32'h0);
    check("txd_after_reset", {31'b0, txd}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
